// File: rtl/gpio_pkg.sv
// Shared definitions for the gpio_irq_ctrl peripheral: register offsets,
// base-address compare width, read-as-zero default and the offset decoder.
package gpio_pkg;

  localparam int unsigned BUS_W = 32;
  localparam int unsigned OFS_W = 8;

  // Register offsets within the 4 KiB peripheral window
  localparam logic [OFS_W-1:0] GPIO_DATA_OFS     = 8'h00;
  localparam logic [OFS_W-1:0] GPIO_DIR_OFS      = 8'h04;
  localparam logic [OFS_W-1:0] GPIO_IN_OFS       = 8'h08;
  localparam logic [OFS_W-1:0] GPIO_SET_OFS      = 8'h0C;
  localparam logic [OFS_W-1:0] GPIO_CLR_OFS      = 8'h10;
  localparam logic [OFS_W-1:0] GPIO_TGL_OFS      = 8'h14;
  localparam logic [OFS_W-1:0] GPIO_IRQ_RISE_OFS = 8'h18;
  localparam logic [OFS_W-1:0] GPIO_IRQ_FALL_OFS = 8'h1C;
  localparam logic [OFS_W-1:0] GPIO_IRQ_STAT_OFS = 8'h20;

  // Address bits below this index are excluded from the base compare
  localparam int unsigned BASE_CMP_W = 12;

  // Value returned for write-only, unmapped or unselected reads
  localparam logic [BUS_W-1:0] RD_DEFAULT = '0;

  typedef enum logic [3:0] {
    RegData,
    RegDir,
    RegIn,
    RegSet,
    RegClr,
    RegTgl,
    RegIrqRise,
    RegIrqFall,
    RegIrqStat,
    RegNone
  } gpio_reg_e;

  // Map a byte offset onto a register identifier; unmapped offsets give RegNone
  function automatic gpio_reg_e decode_ofs(input logic [OFS_W-1:0] ofs);
    gpio_reg_e r;
    case (ofs)
      GPIO_DATA_OFS:     r = RegData;
      GPIO_DIR_OFS:      r = RegDir;
      GPIO_IN_OFS:       r = RegIn;
      GPIO_SET_OFS:      r = RegSet;
      GPIO_CLR_OFS:      r = RegClr;
      GPIO_TGL_OFS:      r = RegTgl;
      GPIO_IRQ_RISE_OFS: r = RegIrqRise;
      GPIO_IRQ_FALL_OFS: r = RegIrqFall;
      GPIO_IRQ_STAT_OFS: r = RegIrqStat;
      default:           r = RegNone;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/gpio_in_sync.sv
// Input path for gpio_irq_ctrl: per-pin synchroniser, optional debounce
// filter (GPIO_DEBOUNCE_EN) and previous-sample register with edge outputs.
module gpio_in_sync #(
  parameter int unsigned GPIO_W       = 32,
  parameter int unsigned SYNC_STAGES  = 2
`ifdef GPIO_DEBOUNCE_EN
  ,
  parameter int unsigned DEBOUNCE_DIV = 1000
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] in_val,
  output logic [GPIO_W-1:0] rise,
  output logic [GPIO_W-1:0] fall
);

  logic [GPIO_W-1:0] sync_q [SYNC_STAGES];
  logic [GPIO_W-1:0] sync_out;
  logic [GPIO_W-1:0] prev_q;

  // Synchroniser chain: stage 0 captures the asynchronous pins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= gpio_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
  localparam int unsigned CNT_W = (DEBOUNCE_DIV > 1) ? $clog2(DEBOUNCE_DIV) : 1;

  logic [CNT_W-1:0]  cnt_q;
  logic              tick;
  logic [GPIO_W-1:0] samp_q;
  logic [GPIO_W-1:0] filt_q;
  logic [GPIO_W-1:0] agree;

  assign tick  = (cnt_q == CNT_W'(DEBOUNCE_DIV - 1));
  assign agree = ~(sync_out ^ samp_q);

  // Prescaler wraps every DEBOUNCE_DIV cycles and raises tick on the last count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // On each tick, a pin's filtered value follows only if two tick samples agree
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_q <= '0;
      filt_q <= '0;
    end else if (tick) begin
      samp_q <= sync_out;
      filt_q <= (agree & sync_out) | (~agree & filt_q);
    end
  end

  assign in_val = filt_q;
`else
  assign in_val = sync_out;
`endif

  // Previous sample of IN for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= '0;
    end else begin
      prev_q <= in_val;
    end
  end

  assign rise = in_val & ~prev_q;
  assign fall = ~in_val & prev_q;

endmodule

// File: rtl/gpio_irq_ctrl.sv
// Memory-mapped GPIO with atomic SET/CLR/TGL, synchronised inputs, per-pin
// edge interrupts and a registered one-cycle-latency read port.
// Optional build macro: GPIO_DEBOUNCE_EN enables the input debounce filter.
module gpio_irq_ctrl
  import gpio_pkg::*;
#(
  parameter int unsigned GPIO_W       = 32,
  parameter logic [31:0] BASE_ADDR    = 32'h4000_0000,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned DEBOUNCE_DIV = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       bus_addr,
  input  logic [31:0]       bus_wdata,
  input  logic              bus_wr_en,
  input  logic              bus_rd_en,
  output logic [31:0]       bus_rdata,
  output logic              bus_rvalid,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic [GPIO_W-1:0] gpio_oe,
  output logic              irq
);

  // Elaboration-time parameter sanity checks
  if (GPIO_W < 1 || GPIO_W > 32) begin : g_bad_width
    $error("GPIO_W must be in 1..32");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (DEBOUNCE_DIV < 1) begin : g_bad_div
    $error("DEBOUNCE_DIV must be at least 1");
  end

  logic [GPIO_W-1:0] data_q, data_d;
  logic [GPIO_W-1:0] dir_q, dir_d;
  logic [GPIO_W-1:0] rise_en_q, rise_en_d;
  logic [GPIO_W-1:0] fall_en_q, fall_en_d;
  logic [GPIO_W-1:0] stat_q, stat_d;
  logic              irq_q;
  logic [31:0]       rdata_q;
  logic              rvalid_q;

  logic              sel;
  logic              wr;
  gpio_reg_e         reg_id;
  logic [GPIO_W-1:0] wdata;
  logic [GPIO_W-1:0] in_val;
  logic [GPIO_W-1:0] rise;
  logic [GPIO_W-1:0] fall;
  logic [31:0]       rd_word;
  logic              unused_addr;

  assign sel    = (bus_addr[31:BASE_CMP_W] == BASE_ADDR[31:BASE_CMP_W]);
  assign wr     = bus_wr_en & sel;
  assign reg_id = decode_ofs(bus_addr[OFS_W-1:0]);
  assign wdata  = bus_wdata[GPIO_W-1:0];

  // Offset is only the low byte; the rest of the window aliases
  assign unused_addr = ^bus_addr[BASE_CMP_W-1:OFS_W];

  gpio_in_sync #(
    .GPIO_W       (GPIO_W),
    .SYNC_STAGES  (SYNC_STAGES)
`ifdef GPIO_DEBOUNCE_EN
    ,
    .DEBOUNCE_DIV (DEBOUNCE_DIV)
`endif
  ) u_in_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .gpio_in (gpio_in),
    .in_val  (in_val),
    .rise    (rise),
    .fall    (fall)
  );

  // Register-file next state: bus writes plus edge-driven status capture
  always_comb begin
    data_d    = data_q;
    dir_d     = dir_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    stat_d    = stat_q;
    if (wr) begin
      case (reg_id)
        RegData:    data_d    = wdata;
        RegDir:     dir_d     = wdata;
        RegSet:     data_d    = data_q | wdata;
        RegClr:     data_d    = data_q & ~wdata;
        RegTgl:     data_d    = data_q ^ wdata;
        RegIrqRise: rise_en_d = wdata;
        RegIrqFall: fall_en_d = wdata;
        RegIrqStat: stat_d    = stat_q & ~wdata;
        default:    ;
      endcase
    end
    // Applied after the clear so a same-cycle edge wins over write-1-to-clear
    stat_d = stat_d | (rise & rise_en_q) | (fall & fall_en_q);
  end

  // Read mux over current register values, so a same-cycle write reads old data
  always_comb begin
    rd_word = RD_DEFAULT;
    if (sel) begin
      case (reg_id)
        RegData:    rd_word[GPIO_W-1:0] = data_q;
        RegDir:     rd_word[GPIO_W-1:0] = dir_q;
        RegIn:      rd_word[GPIO_W-1:0] = in_val;
        RegIrqRise: rd_word[GPIO_W-1:0] = rise_en_q;
        RegIrqFall: rd_word[GPIO_W-1:0] = fall_en_q;
        RegIrqStat: rd_word[GPIO_W-1:0] = stat_q;
        default:    ;
      endcase
    end
  end

  // Register file and interrupt flop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q    <= '0;
      dir_q     <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      stat_q    <= '0;
      irq_q     <= 1'b0;
    end else begin
      data_q    <= data_d;
      dir_q     <= dir_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      stat_q    <= stat_d;
      irq_q     <= |stat_d;
    end
  end

  // Read port: any read strobe is answered; unselected reads return zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= bus_rd_en;
      if (bus_rd_en) begin
        rdata_q <= rd_word;
      end
    end
  end

  assign bus_rdata  = rdata_q;
  assign bus_rvalid = rvalid_q;
  assign gpio_out   = data_q;
  assign gpio_oe    = dir_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// Directed, table-driven bench for gpio_irq_ctrl (default build).
module tb_gpio_irq_ctrl;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam int unsigned SS   = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_wr_en;
  logic        bus_rd_en;
  logic [31:0] bus_rdata;
  logic        bus_rvalid;
  logic [31:0] gpio_in;
  logic [31:0] gpio_out;
  logic [31:0] gpio_oe;
  logic        irq;

  logic [31:0] rdata8;
  logic        rvalid8;
  logic [7:0]  gpio_out8;
  logic [7:0]  gpio_oe8;
  logic        irq8;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  gpio_irq_ctrl #(
    .GPIO_W       (32),
    .BASE_ADDR    (BASE),
    .SYNC_STAGES  (SS),
    .DEBOUNCE_DIV (1000)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_wr_en  (bus_wr_en),
    .bus_rd_en  (bus_rd_en),
    .bus_rdata  (bus_rdata),
    .bus_rvalid (bus_rvalid),
    .gpio_in    (gpio_in),
    .gpio_out   (gpio_out),
    .gpio_oe    (gpio_oe),
    .irq        (irq)
  );

  // Narrow instance on the same bus for the out-of-range bit checks
  gpio_irq_ctrl #(
    .GPIO_W       (8),
    .BASE_ADDR    (BASE),
    .SYNC_STAGES  (SS),
    .DEBOUNCE_DIV (1000)
  ) dut8 (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_wr_en  (bus_wr_en),
    .bus_rd_en  (bus_rd_en),
    .bus_rdata  (rdata8),
    .bus_rvalid (rvalid8),
    .gpio_in    (gpio_in[7:0]),
    .gpio_out   (gpio_out8),
    .gpio_oe    (gpio_oe8),
    .irq        (irq8)
  );

  typedef struct {
    string       name;
    logic        is_wr;
    logic [7:0]  ofs;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic [31:0] exp_out;
    logic [31:0] exp_oe;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    bus_addr  = addr;
    bus_wdata = data;
    bus_wr_en = 1'b1;
    step();
    bus_wr_en = 1'b0;
  endtask

  // Returns rdata/rvalid sampled in the cycle after the accepted strobe
  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data,
                          output logic valid);
    bus_addr  = addr;
    bus_rd_en = 1'b1;
    step();
    bus_rd_en = 1'b0;
    data      = bus_rdata;
    valid     = bus_rvalid;
  endtask

  logic [31:0] rd;
  logic        rv;

  initial begin
    vecs[0]  = '{"wr_dir",   1'b1, 8'h04, 32'h0000_00FF, 32'h0, 32'h0000_0000, 32'h0000_00FF};
    vecs[1]  = '{"wr_data",  1'b1, 8'h00, 32'h0000_00AA, 32'h0, 32'h0000_00AA, 32'h0000_00FF};
    vecs[2]  = '{"rd_dir",   1'b0, 8'h04, 32'h0, 32'h0000_00FF, 32'h0000_00AA, 32'h0000_00FF};
    vecs[3]  = '{"rd_data",  1'b0, 8'h00, 32'h0, 32'h0000_00AA, 32'h0000_00AA, 32'h0000_00FF};
    vecs[4]  = '{"wr_set",   1'b1, 8'h0C, 32'h0000_0001, 32'h0, 32'h0000_00AB, 32'h0000_00FF};
    vecs[5]  = '{"wr_clr",   1'b1, 8'h10, 32'h0000_000A, 32'h0, 32'h0000_00A1, 32'h0000_00FF};
    vecs[6]  = '{"wr_tgl",   1'b1, 8'h14, 32'h0000_00FF, 32'h0, 32'h0000_005E, 32'h0000_00FF};
    vecs[7]  = '{"rd_set",   1'b0, 8'h0C, 32'h0, 32'h0000_0000, 32'h0000_005E, 32'h0000_00FF};
    vecs[8]  = '{"rd_tgl",   1'b0, 8'h14, 32'h0, 32'h0000_0000, 32'h0000_005E, 32'h0000_00FF};
    vecs[9]  = '{"rd_data2", 1'b0, 8'h00, 32'h0, 32'h0000_005E, 32'h0000_005E, 32'h0000_00FF};
    vecs[10] = '{"rd_unmap", 1'b0, 8'h40, 32'h0, 32'h0000_0000, 32'h0000_005E, 32'h0000_00FF};
    vecs[11] = '{"wr_all1",  1'b1, 8'h00, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF, 32'h0000_00FF};
    vecs[12] = '{"rd_all1",  1'b0, 8'h00, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_00FF};

    bus_addr  = '0;
    bus_wdata = '0;
    bus_wr_en = 1'b0;
    bus_rd_en = 1'b0;
    gpio_in   = 32'h1234_5678;
    rst_n     = 1'b0;

    // Reset state
    step();
    step();
    check("rst_gpio_out", gpio_out, 32'h0);
    check("rst_gpio_oe", gpio_oe, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    check("rst_rvalid", {31'h0, bus_rvalid}, 32'h0);
    check("rst_rdata", bus_rdata, 32'h0);
    rst_n = 1'b1;

    // Input synchroniser and IN readback
    repeat (SS + 1) step();
    bus_read(BASE + 32'h08, rd, rv);
    check("in_rdata", rd, 32'h1234_5678);
    check("in_rvalid", {31'h0, rv}, 32'h1);
    step();
    check("rvalid_drop", {31'h0, bus_rvalid}, 32'h0);
    bus_read(BASE + 32'h20, rd, rv);
    check("post_rst_stat", rd, 32'h0);
    check("post_rst_irq", {31'h0, irq}, 32'h0);

    // Table-driven register accesses
    for (int i = 0; i < 13; i++) begin
      if (vecs[i].is_wr) begin
        bus_write(BASE + {24'h0, vecs[i].ofs}, vecs[i].wdata);
      end else begin
        bus_read(BASE + {24'h0, vecs[i].ofs}, rd, rv);
        check({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rd);
        check({vecs[i].name, "_rvalid"}, {31'h0, rv}, 32'h1);
      end
      check({vecs[i].name, "_out"}, gpio_out, vecs[i].exp_out);
      check({vecs[i].name, "_oe"}, gpio_oe, vecs[i].exp_oe);
    end

    // Narrow instance saw DATA = all ones; only 8 bits exist
    check("w8_rdata", rdata8, 32'h0000_00FF);
    check("w8_out", {24'h0, gpio_out8}, 32'h0000_00FF);

    // Simultaneous write and read of DATA returns the pre-write value
    bus_addr  = BASE;
    bus_wdata = 32'h0000_003C;
    bus_wr_en = 1'b1;
    bus_rd_en = 1'b1;
    step();
    bus_wr_en = 1'b0;
    bus_rd_en = 1'b0;
    check("wr_rd_old", bus_rdata, 32'hFFFF_FFFF);
    check("wr_rd_out", gpio_out, 32'h0000_003C);

    // Back-to-back reads
    bus_rd_en = 1'b1;
    bus_addr  = BASE + 32'h04;
    step();
    check("b2b_0_rdata", bus_rdata, 32'h0000_00FF);
    check("b2b_0_rvalid", {31'h0, bus_rvalid}, 32'h1);
    bus_addr = BASE + 32'h00;
    step();
    bus_rd_en = 1'b0;
    check("b2b_1_rdata", bus_rdata, 32'h0000_003C);
    check("b2b_1_rvalid", {31'h0, bus_rvalid}, 32'h1);

    // Unselected accesses change nothing and read zero
    bus_write(32'h5000_0000, 32'h0000_0012);
    bus_write(32'h5000_0004, 32'h0000_0000);
    check("unsel_out", gpio_out, 32'h0000_003C);
    check("unsel_oe", gpio_oe, 32'h0000_00FF);
    bus_read(32'h5000_0004, rd, rv);
    check("unsel_rdata", rd, 32'h0);
    check("unsel_rvalid", {31'h0, rv}, 32'h1);

    // Rising-edge interrupt timing on pin 0
    bus_write(BASE + 32'h18, 32'h1);
    gpio_in[0] = 1'b1;
    repeat (SS) step();
    check("rise_irq_early", {31'h0, irq}, 32'h0);
    step();
    check("rise_irq", {31'h0, irq}, 32'h1);
    bus_read(BASE + 32'h20, rd, rv);
    check("rise_stat", rd, 32'h1);
    bus_write(BASE + 32'h20, 32'h1);
    check("w1c_irq", {31'h0, irq}, 32'h0);

    // Falling edge with fall disabled: no interrupt
    gpio_in[0] = 1'b0;
    repeat (SS + 3) step();
    check("fall_off_irq", {31'h0, irq}, 32'h0);
    bus_read(BASE + 32'h20, rd, rv);
    check("fall_off_stat", rd, 32'h0);

    // W1C on the same edge that captures a new rising event: set wins
    gpio_in[0] = 1'b1;
    repeat (SS) step();
    bus_write(BASE + 32'h20, 32'h1);
    check("collide_irq", {31'h0, irq}, 32'h1);
    bus_read(BASE + 32'h20, rd, rv);
    check("collide_stat", rd, 32'h1);
    bus_write(BASE + 32'h20, 32'h1);
    check("collide_clr_irq", {31'h0, irq}, 32'h0);

    // Reset asserted between the read strobe and its response
    bus_addr  = BASE;
    bus_rd_en = 1'b1;
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1;
    bus_rd_en = 1'b0;
    check("rst_mid_rvalid", {31'h0, bus_rvalid}, 32'h0);
    check("rst_mid_rdata", bus_rdata, 32'h0);
    check("rst_mid_out", gpio_out, 32'h0);
    rst_n = 1'b1;
    step();
    check("rst_mid_after", {31'h0, bus_rvalid}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
